// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered flags, occupancy count and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered latency-1 read.
module fifo_param #(
  parameter int WIDTH_DATA = 288,
  parameter int WIDTH_ADR  = 2,
  parameter int AF_LVL     = (2**WIDTH_ADR) - 1,
  parameter int AE_LVL     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [WIDTH_DATA-1:0] write_dt,
  input  logic                  read_en,
  output logic [WIDTH_DATA-1:0] read_dt,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [WIDTH_ADR:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  output logic [WIDTH_ADR-1:0]  d_wadr,
  output logic [WIDTH_ADR-1:0]  d_radr
);

  localparam int            DEPTH   = 2**WIDTH_ADR;
  localparam int            CW      = WIDTH_ADR + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses pre-edge flags only, so a simultaneous pop never frees room for a push at full.
  assign wr_acc = write_en && !full_q;
  assign rd_acc = read_en && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // A new error in the clearing cycle must not be lost.
    if (write_en && full_q) ovf_d = 1'b1;
    if (read_en && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LVL == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[WIDTH_ADR-1:0]] <= write_dt;
  end

`ifdef FIFO_FWFT_EN
  assign read_dt    = mem[rptr_q[WIDTH_ADR-1:0]];
  assign read_valid = !empty_q;
`else
  logic [WIDTH_DATA-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rptr_q[WIDTH_ADR-1:0]];
    end
  end

  assign read_dt    = rdata_q;
  assign read_valid = rvalid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign d_wadr       = wptr_q[WIDTH_ADR-1:0];
  assign d_radr       = rptr_q[WIDTH_ADR-1:0];

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param (default latency-1 read): flag/count vector table plus a read-data scoreboard.
module tb_fifo_param;
  localparam int WD    = 288;
  localparam int WA    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_en = 1'b0;
  logic [WD-1:0] write_dt = '0;
  logic          read_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [WD-1:0] read_dt;
  logic          read_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [WA:0]   count;
  logic [WA-1:0] d_wadr, d_radr;

  fifo_param #(.WIDTH_DATA(WD), .WIDTH_ADR(WA)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_dt(write_dt),
    .read_en(read_en), .read_dt(read_dt), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
    .d_wadr(d_wadr), .d_radr(d_radr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WD-1:0] mq[$];
  logic [WD-1:0] sbq[$];
  logic [WD-1:0] last_rd;

  typedef struct {
    bit we; int wd; bit re; bit clr;
    int c; bit f; bit e; bit af; bit ae; bit ov; bit un; int wa;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input bit we, input int wd, input bit re, input bit clr,
                     input int c, input bit f, input bit e, input bit af, input bit ae,
                     input bit ov, input bit un, input int wa);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.clr = clr;
    v.c = c; v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.wa = wa;
    vt.push_back(v);
  endtask

  // One clock: drive, predict acceptance from pre-edge model state, then check the data path.
  task automatic step(input bit we, input int wd, input bit re, input bit clr);
    bit wacc, racc;
    logic [WD-1:0] exp;
    write_en = we; write_dt = WD'(wd); read_en = re; clr_err = clr;
    wacc = we && (mq.size() < DEPTH);
    racc = re && (mq.size() > 0);
    if (racc) sbq.push_back(mq.pop_front());
    if (wacc) mq.push_back(WD'(wd));
    @(posedge clk);
    #1;
    chk("read_valid", WD'(read_valid), WD'(racc));
    if (racc) begin
      exp = sbq.pop_front();
      chk("read_dt", read_dt, exp);
      last_rd = exp;
    end else begin
      chk("read_dt_hold", read_dt, last_rd);
    end
    chk("count_vs_model", WD'(count), WD'(mq.size()));
    write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, WD'(count), '0);
    chk({tag, "_empty"}, WD'(empty), WD'(1));
    chk({tag, "_full"}, WD'(full), '0);
    chk({tag, "_ae"}, WD'(almost_empty), WD'(1));
    chk({tag, "_af"}, WD'(almost_full), '0);
    chk({tag, "_ovf"}, WD'(overflow), '0);
    chk({tag, "_unf"}, WD'(underflow), '0);
    chk({tag, "_rd"}, read_dt, '0);
    chk({tag, "_rv"}, WD'(read_valid), '0);
    chk({tag, "_wadr"}, WD'(d_wadr), '0);
    chk({tag, "_radr"}, WD'(d_radr), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last_rd = '0;
    // we wd re clr | count full empty af ae ovf unf wadr
    add(1, 10, 0, 0,  1, 0, 0, 0, 1, 0, 0, 1);
    add(1, 30, 0, 0,  2, 0, 0, 0, 0, 0, 0, 2);
    add(1,  0, 0, 0,  3, 0, 0, 1, 0, 0, 0, 3);
    add(1, 99, 0, 0,  4, 1, 0, 1, 0, 0, 0, 0);
    add(1, 55, 0, 0,  4, 1, 0, 1, 0, 1, 0, 0);
    add(0,  0, 1, 0,  3, 0, 0, 1, 0, 1, 0, 0);
    add(0,  0, 1, 0,  2, 0, 0, 0, 0, 1, 0, 0);
    add(0,  0, 1, 0,  1, 0, 0, 0, 1, 1, 0, 0);
    add(0,  0, 1, 0,  0, 0, 1, 0, 1, 1, 0, 0);
    add(0,  0, 1, 0,  0, 0, 1, 0, 1, 1, 1, 0);
    add(0,  0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0);
    add(1,  7, 0, 0,  1, 0, 0, 0, 1, 0, 0, 1);
    add(1,  8, 0, 0,  2, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 1; i <= 6; i++)
      add(1, i, 1, 0,  2, 0, 0, 0, 0, 0, 0, (2 + i) % 4);
    add(1,  9, 0, 0,  3, 0, 0, 1, 0, 0, 0, 1);
    add(1, 10, 0, 0,  4, 1, 0, 1, 0, 0, 0, 2);
    add(1, 11, 1, 0,  3, 0, 0, 1, 0, 1, 0, 2);
    add(0,  0, 0, 1,  3, 0, 0, 1, 0, 0, 0, 2);

    #12;
    chk_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].we, vt[i].wd, vt[i].re, vt[i].clr);
      chk($sformatf("v%0d_count", i), WD'(count), WD'(vt[i].c));
      chk($sformatf("v%0d_full", i), WD'(full), WD'(vt[i].f));
      chk($sformatf("v%0d_empty", i), WD'(empty), WD'(vt[i].e));
      chk($sformatf("v%0d_af", i), WD'(almost_full), WD'(vt[i].af));
      chk($sformatf("v%0d_ae", i), WD'(almost_empty), WD'(vt[i].ae));
      chk($sformatf("v%0d_ovf", i), WD'(overflow), WD'(vt[i].ov));
      chk($sformatf("v%0d_unf", i), WD'(underflow), WD'(vt[i].un));
      chk($sformatf("v%0d_wadr", i), WD'(d_wadr), WD'(vt[i].wa));
    end

    // Asynchronous reset between clock edges with three words held.
    chk("pre_reset_count", WD'(count), WD'(3));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async");
    mq.delete();
    sbq.delete();
    last_rd = '0;
    #1;
    rst_n = 1'b1;
    step(1, 77, 0, 0);
    chk("post_rst_count", WD'(count), WD'(1));
    step(0, 0, 1, 0);
    chk("post_rst_empty", WD'(empty), WD'(1));

    // Read at empty with a same-cycle write: read rejected, write lands, underflow set.
    step(1, 5, 1, 0);
    chk("rw_empty_count", WD'(count), WD'(1));
    chk("rw_empty_unf", WD'(underflow), WD'(1));
    // Clear and new error together: set wins.
    step(0, 0, 1, 1);
    chk("clr_vs_pop_unf", WD'(underflow), '0);
    step(0, 0, 1, 1);
    chk("clr_vs_new_unf", WD'(underflow), WD'(1));
    chk("final_radr", WD'(d_radr), WD'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
